// File: rtl/core_ex_muldiv_ctrl.sv
// RV32M multi-cycle sequencer: iterative shift-add multiply / restoring divide
// over a shared 64-bit accumulator, with sign correction and flush support.
module core_ex_muldiv_ctrl #(
    parameter int unsigned FAST_SPECIAL = 1
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        flush,
    output logic        op_ready,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [31:0] out_q, out_d;

    logic        signed1, signed2, a_neg, b_neg, div0, ovf, accept;
    logic [31:0] a_abs, b_abs, spec_res_in;
    logic [32:0] sum33, trial;
    logic [63:0] mul_next, div_next, prod;
    logic [31:0] div_sel, result;

    // Operand conditioning at accept time
    always_comb begin
        signed1     = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        signed2     = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg       = signed1 && in1[31];
        b_neg       = signed2 && in2[31];
        a_abs       = a_neg ? (32'd0 - in1) : in1;
        b_abs       = b_neg ? (32'd0 - in2) : in2;
        div0        = op[2] && (in2 == '0);
        ovf         = ((op == 3'd4) || (op == 3'd6)) && (in1 == 32'h8000_0000) && (in2 == '1);
        spec_res_in = '0;
        if (div0) begin
            spec_res_in = op[1] ? in1 : '1;
        end else if (ovf) begin
            spec_res_in = op[1] ? 32'd0 : 32'h8000_0000;
        end
        op_ready = (state_q == S_IDLE) && !flush;
        accept   = op_valid && op_ready;
        busy     = (state_q != S_IDLE);
    end

    // One iteration of each datapath; only the one matching op_q is used
    always_comb begin
        sum33    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next = {sum33, acc_q[31:1]};
        trial    = acc_q[63:31] - {1'b0, b_q};
        div_next = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
        prod     = neg_q ? (64'd0 - acc_q) : acc_q;
        div_sel  = op_q[1] ? acc_q[63:32] : acc_q[31:0];
        if (spec_q) begin
            result = spec_res_q;
        end else if (op_q[2]) begin
            result = neg_q ? (32'd0 - div_sel) : div_sel;
        end else if (op_q == 3'd0) begin
            result = prod[31:0];
        end else begin
            result = prod[63:32];
        end
        out_valid = (state_q == S_DONE) && !flush;
        out       = out_valid ? result : out_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        op_d       = op_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        out_d      = out_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d       = op;
                        b_d        = b_abs;
                        acc_d      = {32'd0, a_abs};
                        neg_d      = (op == 3'd6) ? a_neg : (a_neg ^ b_neg);
                        spec_d     = div0 || ovf;
                        spec_res_d = spec_res_in;
                        cnt_d      = '0;
                        state_d    = ((FAST_SPECIAL != 0) && (div0 || ovf)) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    out_d   = result;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_core_ex_muldiv_ctrl.sv
// Randomized + directed bench for core_ex_muldiv_ctrl, checking both the fast
// special-case build and the full-iteration build against an arithmetic model.
module tb_core_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rest = 1'b0;
    logic        op_valid_f = 1'b0, op_valid_s = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        flush = 1'b0;
    logic        rdy_f, bsy_f, ov_f, rdy_s, bsy_s, ov_s;
    logic [31:0] out_f, out_s;

    logic        use_slow = 1'b0;
    logic        rdy, bsy, ov;
    logic [31:0] ot;

    int errors = 0;
    int checks = 0;

    core_ex_muldiv_ctrl #(.FAST_SPECIAL(1)) u_fast (
        .clk(clk), .rest(rest), .op_valid(op_valid_f), .op(op), .in1(in1), .in2(in2),
        .flush(flush), .op_ready(rdy_f), .busy(bsy_f), .out_valid(ov_f), .out(out_f));

    core_ex_muldiv_ctrl #(.FAST_SPECIAL(0)) u_slow (
        .clk(clk), .rest(rest), .op_valid(op_valid_s), .op(op), .in1(in1), .in2(in2),
        .flush(flush), .op_ready(rdy_s), .busy(bsy_s), .out_valid(ov_s), .out(out_s));

    always #5 clk = ~clk;

    always_comb begin
        rdy = use_slow ? rdy_s : rdy_f;
        bsy = use_slow ? bsy_s : bsy_f;
        ov  = use_slow ? ov_s  : ov_f;
        ot  = use_slow ? out_s : out_f;
    end

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) ||
               ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic set_valid(input bit v);
        if (use_slow) op_valid_s = v; else op_valid_f = v;
    endtask

    // Issue one op and check latency, result, busy-window op_ready and hold
    task automatic do_op(input bit slow, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          exp_lat, got_k;
        bit          ready_bad;
        use_slow  = slow;
        exp       = ref_model(o, a, b);
        exp_lat   = (!slow && is_special(o, a, b)) ? 1 : 33;
        got_k     = 0;
        ready_bad = 0;
        @(negedge clk);
        op = o; in1 = a; in2 = b;
        set_valid(1'b1);
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++; $display("FAIL accept_ready op=%0d got=%b want=1", o, rdy);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) set_valid(1'b0);
            #1;
            if (rdy !== 1'b0) ready_bad = 1;
            if (ov === 1'b1) begin
                got_k = k;
                checks++;
                if (ot !== exp) begin
                    errors++;
                    $display("FAIL result slow=%0d op=%0d a=%h b=%h got=%h want=%h", slow, o, a, b, ot, exp);
                end
                break;
            end
        end
        checks++;
        if (got_k != exp_lat) begin
            errors++; $display("FAIL latency slow=%0d op=%0d got=%0d want=%0d", slow, o, got_k, exp_lat);
        end
        checks++;
        if (ready_bad) begin
            errors++; $display("FAIL ready_low_while_busy slow=%0d op=%0d got=1 want=0", slow, o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rdy !== 1'b1 || bsy !== 1'b0 || ov !== 1'b0 || ot !== exp) begin
            errors++;
            $display("FAIL after_done slow=%0d rdy=%b busy=%b ov=%b out=%h want rdy=1 busy=0 ov=0 out=%h",
                     slow, rdy, bsy, ov, ot, exp);
        end
    endtask

    task automatic test_reset();
        rest = 1'b0;
        #12;
        checks++;
        if (out_f !== 32'd0 || ov_f !== 1'b0 || bsy_f !== 1'b0 ||
            out_s !== 32'd0 || ov_s !== 1'b0 || bsy_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%h/%h ov=%b/%b busy=%b/%b want 0", out_f, out_s, ov_f, ov_s, bsy_f, bsy_s);
        end
        @(negedge clk);
        rest = 1'b1;
        #1;
        checks++;
        if (rdy_f !== 1'b1 || rdy_s !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b/%b want=1/1", rdy_f, rdy_s);
        end
    endtask

    task automatic test_directed();
        do_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD);
        do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2);
        do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(0, 3'd5, 32'd100, 32'd7);
        do_op(0, 3'd7, 32'd100, 32'd7);
    endtask

    task automatic test_special();
        for (int s = 0; s < 2; s++) begin
            do_op(s[0], 3'd5, 32'd5, 32'd0);
            do_op(s[0], 3'd6, 32'd5, 32'd0);
            do_op(s[0], 3'd4, 32'hFFFF_FFF0, 32'd0);
            do_op(s[0], 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
            do_op(s[0], 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_random();
        logic [31:0] corners [8];
        logic [31:0] a, b;
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd3};
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            do_op(i[0], 3'($urandom_range(0, 7)), a, b);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        bit          bad;
        use_slow = 0;
        prev = out_f;
        @(negedge clk);
        op = 3'd4; in1 = 32'd1000; in2 = 32'd3;
        op_valid_f = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) op_valid_f = 1'b0;
        end
        flush = 1'b1;
        op_valid_f = 1'b1;
        #1;
        checks++;
        if (ov_f !== 1'b0 || rdy_f !== 1'b0 || out_f !== prev) begin
            errors++; $display("FAIL flush_run ov=%b rdy=%b out=%h want ov=0 rdy=0 out=%h", ov_f, rdy_f, out_f, prev);
        end
        @(negedge clk);
        flush = 1'b0;
        op_valid_f = 1'b0;
        #1;
        checks++;
        if (rdy_f !== 1'b1 || bsy_f !== 1'b0) begin
            errors++; $display("FAIL flush_recover rdy=%b busy=%b want rdy=1 busy=0", rdy_f, bsy_f);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (ov_f !== 1'b0 || out_f !== prev) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL flush_no_result got=late_strobe_or_out_change want=none out=%h", prev);
        end
    endtask

    task automatic test_flush_idle();
        use_slow = 0;
        @(negedge clk);
        flush = 1'b1; op_valid_f = 1'b1; op = 3'd0; in1 = 32'd2; in2 = 32'd2;
        #1;
        checks++;
        if (rdy_f !== 1'b0) begin
            errors++; $display("FAIL flush_idle_ready got=%b want=0", rdy_f);
        end
        @(negedge clk);
        flush = 1'b0; op_valid_f = 1'b0;
        #1;
        checks++;
        if (bsy_f !== 1'b0) begin
            errors++; $display("FAIL flush_idle_accept busy=%b want=0", bsy_f);
        end
    endtask

    task automatic test_flush_done();
        logic [31:0] prev;
        bit          bad;
        use_slow = 0;
        prev = out_f;
        @(negedge clk);
        op = 3'd0; in1 = 32'd9; in2 = 32'd9;
        op_valid_f = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) op_valid_f = 1'b0;
        end
        flush = 1'b1;
        #1;
        checks++;
        if (ov_f !== 1'b0 || out_f !== prev) begin
            errors++; $display("FAIL flush_done ov=%b out=%h want ov=0 out=%h", ov_f, out_f, prev);
        end
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (ov_f !== 1'b0 || bsy_f !== 1'b0 || out_f !== prev) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL flush_done_after got=strobe_or_busy_or_out_change want=idle out=%h", prev);
        end
    endtask

    task automatic test_reset_mid();
        use_slow = 0;
        @(negedge clk);
        op = 3'd0; in1 = 32'd11; in2 = 32'd13;
        op_valid_f = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) op_valid_f = 1'b0;
        end
        rest = 1'b0;
        #1;
        checks++;
        if (out_f !== 32'd0 || bsy_f !== 1'b0 || ov_f !== 1'b0) begin
            errors++; $display("FAIL reset_mid out=%h busy=%b ov=%b want out=0 busy=0 ov=0", out_f, bsy_f, ov_f);
        end
        @(negedge clk);
        rest = 1'b1;
        do_op(0, 3'd0, 32'd3, 32'd4);
    endtask

    task automatic test_back_to_back();
        int          k1, k2;
        logic [31:0] r1, r2;
        use_slow = 0;
        k1 = 0; k2 = 0; r1 = '0; r2 = '0;
        @(negedge clk);
        op = 3'd3; in1 = 32'h1234_5678; in2 = 32'h9ABC_DEF0;
        op_valid_f = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) begin op = 3'd5; in1 = 32'd1_000_000; in2 = 32'd37; end
            if (k == 35) op_valid_f = 1'b0;
            #1;
            if (k == 34) begin
                checks++;
                if (rdy_f !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready got=%b want=1", rdy_f);
                end
            end
            if (ov_f === 1'b1) begin
                if (k1 == 0) begin k1 = k; r1 = out_f; end
                else if (k2 == 0) begin k2 = k; r2 = out_f; end
            end
        end
        checks++;
        if (k1 != 33 || k2 != 67) begin
            errors++; $display("FAIL b2b_timing got=%0d,%0d want=33,67", k1, k2);
        end
        checks++;
        if (r1 !== ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0) || r2 !== ref_model(3'd5, 32'd1_000_000, 32'd37)) begin
            errors++;
            $display("FAIL b2b_results got=%h,%h want=%h,%h", r1, r2,
                     ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), ref_model(3'd5, 32'd1_000_000, 32'd37));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_flush();
        test_flush_idle();
        test_flush_done();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
